stopwatch_timer_core: RTL

//  Parametrised time core for the Basys-3 stopwatch with count-up (stopwatch) and count-down (timer) modes.

---
 rtl/stopwatch_timer_core.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/stopwatch_timer_core.sv
// Stopwatch/timer time core: BCD mm:ss counter with up/down modes, field adjust,
// end-of-countdown alarm and a circular lap-capture FIFO that overwrites its oldest entry.
module stopwatch_timer_core #(
    parameter int MIN_MAX   = 59,
    parameter int LAP_DEPTH = 4,
    parameter int LAP_AW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1hz,
    input  logic              tick_2hz,
    input  logic              mode_down,
    input  logic              start_stop,
    input  logic              clear,
    input  logic              adj,
    input  logic              sel,
    input  logic              lap,
    input  logic              lap_rd,
    output logic [3:0]        min_tens,
    output logic [3:0]        min_ones,
    output logic [3:0]        sec_tens,
    output logic [3:0]        sec_ones,
    output logic              running,
    output logic              alarm,
    output logic [15:0]       lap_time,
    output logic [LAP_AW:0]   lap_count,
    output logic              lap_full,
    output logic              lap_empty
);

    typedef enum logic [1:0] {IDLE, RUN, ADJUST, DONE} state_t;

    localparam logic [7:0]      MIN_TOP = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
    localparam logic [LAP_AW:0] DEPTH_C = (LAP_AW + 1)'(LAP_DEPTH);

    state_t      state, state_next;
    logic        dir, dir_next;
    logic [7:0]  mins, secs, mins_next, secs_next;

    function automatic logic [7:0] min_inc(input logic [7:0] v);
        if (v == MIN_TOP)        return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] min_dec(input logic [7:0] v);
        if (v == 8'h00)          return MIN_TOP;
        else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                     return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] sec_inc(input logic [7:0] v);
        if (v == 8'h59)          return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                     return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] sec_dec(input logic [7:0] v);
        if (v == 8'h00)          return 8'h59;
        else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                     return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign mins = {min_tens, min_ones};
    assign secs = {sec_tens, sec_ones};

    always_comb begin
        state_next = state;
        dir_next   = dir;
        mins_next  = mins;
        secs_next  = secs;
        if (clear) begin
            state_next = IDLE;
            mins_next  = 8'h00;
            secs_next  = 8'h00;
        end else if (adj && state != DONE) begin
            state_next = ADJUST;
            if (state == ADJUST && tick_2hz) begin
                if (sel) secs_next = sec_inc(secs);
                else     mins_next = min_inc(mins);
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_stop && !(mode_down && mins == 8'h00 && secs == 8'h00)) begin
                        state_next = RUN;
                        dir_next   = mode_down;
                    end
                end
                RUN: begin
                    if (start_stop) begin
                        state_next = IDLE;
                    end else if (tick_1hz) begin
                        if (!dir) begin
                            secs_next = sec_inc(secs);
                            if (secs == 8'h59) mins_next = min_inc(mins);
                        end else begin
                            secs_next = sec_dec(secs);
                            if (secs == 8'h00) mins_next = min_dec(mins);
                            if (mins == 8'h00 && secs == 8'h01) state_next = DONE;
                        end
                    end
                end
                ADJUST:  state_next = IDLE;
                DONE:    if (start_stop) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    logic [15:0]       mem [LAP_DEPTH];
    logic [LAP_AW-1:0] wr_ptr, rd_ptr, wr_next, rd_next;
    logic [LAP_AW:0]   count_next;
    logic [15:0]       entry, head_next;
    logic              push, pop, advance;

    assign entry = {min_tens, min_ones, sec_tens, sec_ones};

    // A push into a full FIFO advances the read pointer exactly like a pop,
    // so overwrite-oldest and pop+push share the same pointer path.
    always_comb begin
        push       = !clear && lap && state == RUN;
        pop        = !clear && lap_rd && lap_count != '0;
        advance    = pop || (push && lap_count == DEPTH_C);
        wr_next    = wr_ptr;
        rd_next    = rd_ptr;
        count_next = lap_count;
        if (clear) begin
            wr_next    = '0;
            rd_next    = '0;
            count_next = '0;
        end else begin
            if (push)    wr_next = wr_ptr + LAP_AW'(1);
            if (advance) rd_next = rd_ptr + LAP_AW'(1);
            if (push && !advance)      count_next = lap_count + (LAP_AW + 1)'(1);
            else if (advance && !push) count_next = lap_count - (LAP_AW + 1)'(1);
        end
        if (count_next == '0)              head_next = '0;
        else if (push && wr_ptr == rd_next) head_next = entry;
        else                               head_next = mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dir       <= 1'b0;
            min_tens  <= '0;
            min_ones  <= '0;
            sec_tens  <= '0;
            sec_ones  <= '0;
            running   <= 1'b0;
            alarm     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lap_count <= '0;
            lap_time  <= '0;
            lap_full  <= 1'b0;
            lap_empty <= 1'b1;
        end else begin
            state     <= state_next;
            dir       <= dir_next;
            {min_tens, min_ones} <= mins_next;
            {sec_tens, sec_ones} <= secs_next;
            running   <= state_next == RUN;
            alarm     <= state_next == DONE;
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            lap_count <= count_next;
            lap_time  <= head_next;
            lap_full  <= count_next == DEPTH_C;
            lap_empty <= count_next == '0;
        end
    end

endmodule
